// File: rtl/double_ne_mask_packer_if.sv
// Handshake bundle between the double_ne result stream, the mask packer and its consumer.
interface double_ne_mask_packer_if #(parameter int WIDTH = 32);
  logic             in_ne;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] out_mask;
  logic [6:0]       out_count;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_ne, in_valid, flush, out_ready,
    input  in_ready, out_mask, out_count, out_last, out_valid
  );

  modport slave (
    input  in_ne, in_valid, flush, out_ready,
    output in_ready, out_mask, out_count, out_last, out_valid
  );
endinterface

// File: rtl/double_ne_mask_packer.sv
// Packs 1-bit compare results LSB-first into WIDTH-bit mask words with fill count,
// closing a word when it fills or on flush; one-deep output register with valid/ready.
module double_ne_mask_packer #(
  parameter int WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  double_ne_mask_packer_if.slave bus
);
  localparam logic [6:0] LAST_IDX = 7'(WIDTH - 1);

  logic [WIDTH-1:0] acc, acc_nxt, mask_nxt, out_mask_q;
  logic [6:0]       fill, cnt_nxt, out_count_q;
  logic             flush_pend, out_valid_q, out_last_q;
  logic             out_free, in_ready, accept, flush_eff, close;

  always_comb begin
    out_free  = !out_valid_q | bus.out_ready;
    in_ready  = !flush_pend & ((fill < LAST_IDX) | out_free);
    accept    = bus.in_valid & in_ready;
    flush_eff = (bus.flush | flush_pend) & out_free;
    // A flush that coincides with the final bit closes just that one full word.
    close     = (accept & (fill == LAST_IDX)) | (flush_eff & ((fill != 7'd0) | accept));
    cnt_nxt   = fill + {6'd0, accept};
    acc_nxt   = acc;
    mask_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && fill == 7'(i)) acc_nxt[i] = bus.in_ne;
      mask_nxt[i] = acc_nxt[i] & (7'(i) < cnt_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      fill        <= '0;
      flush_pend  <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // A flush that cannot be honoured now waits for the output slot; otherwise it is consumed.
      flush_pend <= (bus.flush | flush_pend) & !out_free;
      if (close) begin
        acc         <= '0;
        fill        <= '0;
        out_mask_q  <= mask_nxt;
        out_count_q <= cnt_nxt;
        out_last_q  <= flush_eff;
        out_valid_q <= 1'b1;
      end else begin
        acc  <= acc_nxt;
        fill <= cnt_nxt;
        if (bus.out_ready) out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_double_ne_mask_packer.sv
// Bench for double_ne_mask_packer (WIDTH=8): directed vector table, reset sequence,
// then random traffic against a queue-based reference model.
module tb_double_ne_mask_packer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  double_ne_mask_packer_if #(.WIDTH(W)) bus ();
  double_ne_mask_packer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    bit ne, v, fl, ordy;
    bit rdy, ov;
    logic [7:0] mask;
    logic [6:0] cnt;
    bit last;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(bit ne, bit v, bit fl, bit ordy, bit rdy, bit ov,
                     logic [7:0] mask, logic [6:0] cnt, bit last);
    vec_t r;
    r.ne = ne; r.v = v; r.fl = fl; r.ordy = ordy; r.rdy = rdy; r.ov = ov;
    r.mask = mask; r.cnt = cnt; r.last = last;
    tbl.push_back(r);
  endtask

  task automatic drive(bit ne, bit v, bit fl, bit ordy);
    @(negedge clk);
    bus.in_ne = ne; bus.in_valid = v; bus.flush = fl; bus.out_ready = ordy;
  endtask

  task automatic step(vec_t r);
    drive(r.ne, r.v, r.fl, r.ordy);
    #1 chk("in_ready", bus.in_ready, r.rdy);
    @(posedge clk);
    #1 chk("out_valid", bus.out_valid, r.ov);
    if (r.ov) begin
      chk("out_mask", bus.out_mask, r.mask);
      chk("out_count", bus.out_count, r.cnt);
      chk("out_last", bus.out_last, r.last);
    end
  endtask

  initial begin
    bit s1[8];
    bit s6[8];
    s1 = '{1, 0, 1, 1, 0, 0, 0, 1};
    s6 = '{0, 1, 0, 1, 1, 0, 1, 0};
    bus.in_ne = 0; bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;

    // full word, out_ready=1
    for (int i = 0; i < 7; i++) add(s1[i], 1, 0, 1, 1, 0, 0, 0, 0);
    add(s1[7], 1, 0, 1, 1, 1, 8'h8D, 8, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // partial word by flush, then empty flush
    add(1, 1, 0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 1, 8'h03, 3, 1);
    add(0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // stalled output: 7 more bits accepted, 8th waits
    add(1, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 8'h01, 2, 1);
    for (int i = 0; i < 7; i++) add(1, 1, 0, 0, 1, 1, 8'h01, 2, 1);
    add(0, 1, 0, 0, 0, 1, 8'h01, 2, 1);
    add(0, 1, 0, 0, 0, 1, 8'h01, 2, 1);
    add(0, 1, 0, 1, 1, 1, 8'h7F, 8, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // final bit together with flush
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 1, 8'h80, 8, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // flush pending behind a stalled word
    add(1, 1, 1, 0, 1, 1, 8'h01, 1, 1);
    add(1, 1, 0, 0, 1, 1, 8'h01, 1, 1);
    add(1, 1, 0, 0, 1, 1, 8'h01, 1, 1);
    add(0, 0, 1, 0, 1, 1, 8'h01, 1, 1);
    add(1, 1, 0, 0, 0, 1, 8'h01, 1, 1);
    add(0, 0, 0, 1, 0, 1, 8'h03, 2, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_mask", bus.out_mask, 0);
    chk("rst out_count", bus.out_count, 0);
    chk("rst in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // reset mid-word while a word is held
    tbl.delete();
    add(1, 1, 1, 0, 1, 1, 8'h01, 1, 1);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 1, 1, 8'h01, 1, 1);
    foreach (tbl[i]) step(tbl[i]);
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst out_mask", bus.out_mask, 0);
    chk("midrst out_count", bus.out_count, 0);
    chk("midrst out_last", bus.out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post-rst in_ready", bus.in_ready, 1);
    tbl.delete();
    for (int i = 0; i < 7; i++) add(s6[i], 1, 0, 1, 1, 0, 0, 0, 0);
    add(s6[7], 1, 0, 1, 1, 1, 8'h5A, 8, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    foreach (tbl[i]) step(tbl[i]);

    // random traffic against the reference model
    begin
      int q[$];
      bit pend, m_ov, m_last;
      int m_cnt;
      logic [7:0] m_mask;
      pend = 0; m_ov = 0; m_last = 0; m_cnt = 0; m_mask = 0;
      repeat (600) begin
        bit ne, v, fl, ordy, free, erdy, feff, acc;
        ne   = 1'($urandom_range(0, 1));
        v    = $urandom_range(0, 9) < 7;
        fl   = $urandom_range(0, 9) == 0;
        ordy = $urandom_range(0, 9) < 6;
        drive(ne, v, fl, ordy);
        #1;
        free = !m_ov || ordy;
        erdy = !pend && (q.size() < W - 1 || free);
        chk("rnd in_ready", bus.in_ready, erdy);
        acc = v && erdy;
        if (acc) q.push_back(int'(ne));
        feff = (fl || pend) && free;
        if ((acc && q.size() == W) || (feff && q.size() > 0)) begin
          m_mask = 0;
          foreach (q[i]) if (q[i] != 0) m_mask = m_mask + 8'(1 << i);
          m_cnt = q.size();
          m_last = feff;
          m_ov = 1;
          q.delete();
        end else if (ordy) begin
          m_ov = 0;
        end
        pend = (fl || pend) && !free;
        @(posedge clk);
        #1 chk("rnd out_valid", bus.out_valid, m_ov);
        if (m_ov) begin
          chk("rnd out_mask", bus.out_mask, m_mask);
          chk("rnd out_count", bus.out_count, 64'(m_cnt));
          chk("rnd out_last", bus.out_last, m_last);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
